// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexes two 16-bit two-digit cathode encodings (left and right
// score) onto a 4-digit common-anode display. Digit order on the anodes is
// an[3]=left tens, an[2]=left ones, an[1]=right tens, an[0]=right ones.
// Score inputs are copied into shadow registers only at the frame boundary,
// so a digit never changes part-way through a scan. Each digit slot begins
// with BLANK_CYC all-off cycles so the previous digit cannot ghost.
// Optional feature: define SEG_BLINK_EN to add the blink input and the
// frame-based blink counter.
module seven_seg_scanner #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score_l,
    input  logic [15:0] score_r,
`ifdef SEG_BLINK_EN
    input  logic        blink,
`endif
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int DIGIT_CYC = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W     = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_DRIVE = 1'b1;

    // Reject parameter sets that would break the blanking guarantee.
    if (DIGIT_CYC < 2 || BLANK_CYC < 1 || BLANK_CYC >= DIGIT_CYC ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > 256) begin : g_bad_param
        $error("seven_seg_scanner: illegal parameter combination");
    end

    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel;
    logic             state;
    logic [15:0]      shadow_l;
    logic [15:0]      shadow_r;
    logic             boundary;
    logic             vis;
    logic [7:0]       cur_byte;
    logic             drive;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    assign boundary = (sel == 2'd3) && (cnt == CNT_LAST);

    // Prescaler, slot select and per-slot BLANK/DRIVE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= CNT_ZERO;
            sel   <= 2'd0;
            state <= ST_BLANK;
        end else if (cnt == CNT_LAST) begin
            // Every slot starts blank since BLANK_CYC is at least 1.
            cnt   <= CNT_ZERO;
            sel   <= sel + 2'd1;
            state <= ST_BLANK;
        end else begin
            cnt   <= cnt + CNT_ONE;
            state <= ((cnt + CNT_ONE) < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
        end
    end

    // Shadow copies of the scores, refreshed only at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_l <= 16'hC0C0;
            shadow_r <= 16'hC0C0;
        end else if (boundary) begin
            shadow_l <= score_l;
            shadow_r <= score_r;
        end
    end

`ifdef SEG_BLINK_EN
    localparam logic [7:0] FC_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] fcnt;

    // Blink phase: count frames, flip visibility every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= 8'd0;
            vis  <= 1'b1;
        end else if (!blink) begin
            fcnt <= 8'd0;
            vis  <= 1'b1;
        end else if (frame_tick) begin
            // frame_tick lands on the first (blank) cycle of sel0, so the
            // visibility change never cuts into a driven digit.
            if (fcnt == FC_LAST) begin
                fcnt <= 8'd0;
                vis  <= ~vis;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end
`else
    assign vis = 1'b1;
`endif

    // Select the digit byte for the current slot and decode the outputs
    always_comb begin
        cur_byte = 8'hFF;
        case (sel)
            2'd0:    cur_byte = shadow_l[15:8];
            2'd1:    cur_byte = shadow_l[7:0];
            2'd2:    cur_byte = shadow_r[15:8];
            default: cur_byte = shadow_r[7:0];
        endcase
        drive   = (state == ST_DRIVE) && vis;
        an_nxt  = 4'hF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (drive) begin
            an_nxt  = ~(4'b1000 >> sel);
            seg_nxt = cur_byte[6:0];
            dp_nxt  = cur_byte[7];
        end
    end

    // Registered outputs: everything appears one cycle after its slot state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_tick <= boundary;
        end
    end

endmodule
